// File: rtl/conv3d_pkg.sv
// conv3d shared definitions: write-master FSM states and beat sizing.
// Default build constants assume the 128-bit result datapath.
`timescale 1ns/1ps
package conv3d_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } wmst_state_e;

  localparam int DW_DEF     = 128;
  localparam int BYTES      = DW_DEF / 8;
  localparam int BEAT_SHIFT = $clog2(BYTES);

  function automatic int beat_shift(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/conv3d_wmst_fifo.sv
// conv3d write-master result FIFO: first-word-fall-through register array.
// A push into a full FIFO is refused even when a pop happens alongside.
`timescale 1ns/1ps
module conv3d_wmst_fifo #(
  parameter int DW         = 128,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DW-1:0]                 din,
  output logic [DW-1:0]                 dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          push_ok, pop_ok;

  // Accept decisions, pointer advance and occupancy tracking.
  always_comb begin
    push_ok  = push & ~full_q;
    pop_ok   = pop & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
    full_d = (count_d == CW'(FIFO_DEPTH));
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: rtl/conv3d_wmst.sv
// conv3d Avalon-MM write master: buffers results, issues single-beat writes.
// Optional sticky overflow flag enabled by macro CONV3D_WMST_OVF_EN.
`timescale 1ns/1ps
module conv3d_wmst
  import conv3d_pkg::*;
#(
  parameter int AW         = 30,
  parameter int DW         = 128,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_fixed_location,
  input  logic [AW-1:0]     ctrl_write_base,
  input  logic [AW-1:0]     ctrl_write_length,
  input  logic              ctrl_go,
  output logic              ctrl_done,
  input  logic              user_write_buffer,
  input  logic [DW-1:0]     user_write_input_data,
  output logic              user_buffer_full,
  output logic [AW-1:0]     master_address,
  output logic              master_write,
  output logic [DW/8-1:0]   master_byteenable,
  output logic [DW-1:0]     master_writedata,
  input  logic              master_waitrequest,
  output logic              ovf_err
);

  localparam int NB = DW / 8;
  localparam int SH = beat_shift(DW);

  wmst_state_e   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] rem_q, rem_d;
  logic          fixed_q, fixed_d;
  logic          done_q, done_d;
  logic [AW-1:0] beats;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          accept;
  logic [$clog2(FIFO_DEPTH):0] unused_count;

  conv3d_wmst_fifo #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (user_write_buffer),
    .pop   (pop),
    .din   (user_write_input_data),
    .dout  (master_writedata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (unused_count)
  );

  assign beats        = ctrl_write_length >> SH;
  assign master_write = (state_q == RUN) & ~fifo_empty;
  assign accept       = master_write & ~master_waitrequest;

  // Transfer sequencing, address stepping and beat countdown.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    fixed_d = fixed_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctrl_go) begin
          addr_d  = ctrl_write_base;
          rem_d   = beats;
          fixed_d = ctrl_fixed_location;
          if (beats == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          pop   = 1'b1;
          rem_d = rem_q - 1'b1;
          if (!fixed_q) begin
            addr_d = addr_q + AW'(NB);
          end
          if (rem_q == AW'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and datapath registers; done pulse registered with DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      fixed_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      fixed_q <= fixed_d;
      done_q  <= done_d;
    end
  end

  assign ctrl_done         = done_q;
  assign user_buffer_full  = fifo_full;
  assign master_address    = addr_q;
  assign master_byteenable = '1;

`ifdef CONV3D_WMST_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky drop flag; a new accepted go clears it unless a drop coincides.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && ctrl_go) begin
      ovf_d = 1'b0;
    end
    if (user_write_buffer && fifo_full) begin
      ovf_d = 1'b1;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv3d_wmst.sv
// conv3d_wmst bench: transfer table plus overflow and mid-transfer reset.
// Expected data comes from a bench-side queue model of the FIFO.
`timescale 1ns/1ps
module tb_conv3d_wmst;

  localparam int AW = 30;
  localparam int DW = 128;
  localparam int NB = 16;
  localparam int FD = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          fixed;
  logic [AW-1:0] wbase;
  logic [AW-1:0] wlen;
  logic          go;
  logic          cdone;
  logic          wbuf;
  logic [DW-1:0] wdata;
  logic          bfull;
  logic [AW-1:0] maddr;
  logic          mwrite;
  logic [NB-1:0] mbe;
  logic [DW-1:0] mdata;
  logic          wreq;
  logic          ovf;

  always #5 clk = ~clk;

  conv3d_wmst #(
    .AW         (AW),
    .DW         (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ctrl_fixed_location   (fixed),
    .ctrl_write_base       (wbase),
    .ctrl_write_length     (wlen),
    .ctrl_go               (go),
    .ctrl_done             (cdone),
    .user_write_buffer     (wbuf),
    .user_write_input_data (wdata),
    .user_buffer_full      (bfull),
    .master_address        (maddr),
    .master_write          (mwrite),
    .master_byteenable     (mbe),
    .master_writedata      (mdata),
    .master_waitrequest    (wreq),
    .ovf_err               (ovf)
  );

  typedef struct {
    logic          fx;
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    int            npush;
    int            ss;
    int            sn;
    int            beats;
    int            done;
  } vec_t;

  vec_t          tbl[9];
  logic [DW-1:0] model[$];
  int            errors = 0;
  int            checks = 0;
  int            seq = 0;
  logic          exp_ovf;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      wbuf  = 1'b1;
      wdata = {32'hDA7A0000 | 32'(seq), 32'(seq * 3), ~32'(seq), 32'(seq)};
      if (model.size() < FD) model.push_back(wdata);
      seq++;
    end
    @(posedge clk);
    #1;
    wbuf = 1'b0;
  endtask

  task automatic run_xfer(input string nm, input logic fx,
                          input logic [AW-1:0] base, input logic [AW-1:0] len,
                          input int ss, input int sn,
                          input int exp_beats, input int exp_done);
    logic [AW-1:0] ea;
    int beats;
    int done_k;
    beats  = 0;
    done_k = -1;
    @(posedge clk);
    #1;
    fixed = fx;
    wbase = base;
    wlen  = len;
    go    = 1'b1;
    for (int k = 1; k <= exp_done + 2; k++) begin
      @(posedge clk);
      #1;
      go   = 1'b0;
      wreq = (k >= ss) && (k < ss + sn);
      @(negedge clk);
      if (mwrite) begin
        ea = fx ? base : base + AW'(beats * NB);
        chk({nm, " addr"}, DW'(maddr), DW'(ea));
        if (model.size() > 0) begin
          chk({nm, " data"}, mdata, model[0]);
        end else begin
          chk({nm, " write with empty model"}, 1, 0);
        end
        if (!wreq) begin
          beats++;
          if (model.size() > 0) void'(model.pop_front());
        end
      end
      if (cdone) begin
        if (done_k < 0) done_k = k;
        else chk({nm, " extra done"}, DW'(k), DW'(done_k));
      end
    end
    wreq = 1'b0;
    chk({nm, " beats"}, DW'(beats), DW'(exp_beats));
    chk({nm, " done cycle"}, DW'(done_k), DW'(exp_done));
    chk({nm, " byteenable"}, DW'(mbe), DW'(16'hFFFF));
    chk({nm, " ovf"}, DW'(ovf), 0);
  endtask

  initial begin
`ifdef CONV3D_WMST_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    tbl[0] = '{1'b0, 30'h1000,     30'd64, 4, 0, 0, 4, 5};
    tbl[1] = '{1'b0, 30'h1000,     30'd64, 4, 2, 3, 4, 8};
    tbl[2] = '{1'b1, 30'h2000,     30'd48, 3, 0, 0, 3, 4};
    tbl[3] = '{1'b0, 30'h2800,     30'd0,  2, 0, 0, 0, 1};
    tbl[4] = '{1'b0, 30'h2900,     30'd15, 0, 0, 0, 0, 1};
    tbl[5] = '{1'b0, 30'h3000,     30'd32, 0, 0, 0, 2, 3};
    tbl[6] = '{1'b0, 30'h3FFFFFF0, 30'd32, 2, 0, 0, 2, 3};
    tbl[7] = '{1'b0, 30'h3100,     30'd16, 3, 0, 0, 1, 2};
    tbl[8] = '{1'b0, 30'h3200,     30'd32, 0, 1, 1, 2, 4};

    rst   = 1'b1;
    fixed = 1'b0;
    wbase = '0;
    wlen  = '0;
    go    = 1'b0;
    wbuf  = 1'b0;
    wdata = '0;
    wreq  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset done", DW'(cdone), 0);
    chk("reset full", DW'(bfull), 0);
    chk("reset addr", DW'(maddr), 0);
    chk("reset write", DW'(mwrite), 0);
    chk("reset wdata", mdata, 0);
    chk("reset ovf", DW'(ovf), 0);

    for (int i = 0; i < 9; i++) begin
      push_words(tbl[i].npush);
      run_xfer($sformatf("vec%0d", i), tbl[i].fx, tbl[i].base, tbl[i].len,
               tbl[i].ss, tbl[i].sn, tbl[i].beats, tbl[i].done);
    end

    push_words(FD);
    @(negedge clk);
    chk("full after 32", DW'(bfull), 1);
    chk("ovf before drop", DW'(ovf), 0);
    push_words(1);
    @(negedge clk);
    chk("ovf after drop", DW'(ovf), DW'(exp_ovf));
    chk("full after drop", DW'(bfull), 1);
    run_xfer("drain32", 1'b0, 30'h4000, 30'd512, 0, 0, 32, 33);
    chk("not full after drain", DW'(bfull), 0);
    push_words(1);
    run_xfer("fresh1", 1'b0, 30'h4800, 30'd16, 0, 0, 1, 2);

    push_words(4);
    @(posedge clk);
    #1;
    fixed = 1'b0;
    wbase = 30'h5000;
    wlen  = 30'd64;
    go    = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk);
      #1;
      go = 1'b0;
      @(negedge clk);
      chk("rstmid write", DW'(mwrite), 1);
      chk("rstmid addr", DW'(maddr), DW'(30'h5000 + AW'((k - 1) * NB)));
      chk("rstmid data", mdata, model[0]);
      void'(model.pop_front());
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model.delete();
    @(negedge clk);
    chk("rstmid out write", DW'(mwrite), 0);
    chk("rstmid out addr", DW'(maddr), 0);
    chk("rstmid out done", DW'(cdone), 0);
    chk("rstmid out full", DW'(bfull), 0);
    chk("rstmid out wdata", mdata, 0);
    chk("rstmid out ovf", DW'(ovf), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstmid no done", DW'(cdone), 0);
    end
    push_words(2);
    run_xfer("after rst", 1'b0, 30'h6000, 30'd32, 0, 0, 2, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
